// File: rtl/casca_pkg.sv
// Shared types and constants for the casca channel sequencer.
package casca_pkg;

  localparam int unsigned NUM_CH               = 3;
  localparam int unsigned DEFAULT_DWELL_CYCLES = 100_000_000;
  localparam int unsigned DEFAULT_GAP_CYCLES   = 50_000;

  typedef enum logic [2:0] {
    S_OFF,
    S_MANUAL,
    S_CH1,
    S_GAP1,
    S_CH2,
    S_GAP2,
    S_CH3,
    S_GAP3
  } state_e;

  // Switch bundle carried through the synchronizer as one vector.
  typedef struct packed {
    logic [NUM_CH-1:0] manual;
    logic              chase;
    logic [1:0]        led;
  } sw_t;

  // Next lit channel after a CH or GAP state; CH3/GAP3 wrap to CH1.
  function automatic state_e chase_next(input state_e s);
    case (s)
      S_CH1, S_GAP1: return S_CH2;
      S_CH2, S_GAP2: return S_CH3;
      default:       return S_CH1;
    endcase
  endfunction

  // Break-before-make gap that follows a lit channel.
  function automatic state_e gap_of(input state_e s);
    case (s)
      S_CH1:   return S_GAP1;
      S_CH2:   return S_GAP2;
      default: return S_GAP3;
    endcase
  endfunction

endpackage

// File: rtl/casca_sequencer_if.sv
// Switch, PWM and indicator signals of the casca sequencer.
interface casca_sequencer_if;

  logic [casca_pkg::NUM_CH-1:0] sw_manual;
  logic                         sw_chase;
  logic [1:0]                   sw_led;
  logic [casca_pkg::NUM_CH-1:0] pwm_in;
  logic [casca_pkg::NUM_CH-1:0] pwm_out;
  logic [1:0]                   led;
  logic [1:0]                   chase_step;

  modport master (
    output sw_manual, sw_chase, sw_led, pwm_in,
    input  pwm_out, led, chase_step
  );

  modport slave (
    input  sw_manual, sw_chase, sw_led, pwm_in,
    output pwm_out, led, chase_step
  );

endinterface

// File: rtl/casca_sequencer_sw_sync.sv
// Parameterized-width 2-flop synchronizer with synchronous reset.
module sw_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops to settle asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/casca_sequencer.sv
// Three-channel PWM gate: manual per-channel enable or timed chase.
module casca_sequencer
  import casca_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
  parameter int unsigned GAP_CYCLES   = DEFAULT_GAP_CYCLES
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  casca_sequencer_if.slave   bus
);

  localparam int unsigned DG_MAX  = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX = (DG_MAX > 2) ? DG_MAX : 2;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned DWELL_LAST = DWELL_CYCLES - 1;
  localparam int unsigned GAP_LAST   = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  localparam logic [CNT_W-1:0] DWELL_LAST_C = CNT_W'(DWELL_LAST);
  localparam logic [CNT_W-1:0] GAP_LAST_C   = CNT_W'(GAP_LAST);

  sw_t sw_raw;
  sw_t sw_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] man_q;
  logic [NUM_CH-1:0] en_c;
  logic [1:0]        step_c;

  assign sw_raw = '{manual: bus.sw_manual, chase: bus.sw_chase, led: bus.sw_led};

  sw_sync #(.WIDTH($bits(sw_t))) u_sw_sync (
    .clk (clk_50MHz),
    .rst (rst),
    .d   (sw_raw),
    .q   (sw_s)
  );

  // State, dwell/gap counter and the manual mask that travels with the state.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      man_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      man_q   <= sw_s.manual;
    end
  end

  // Mode selection and chase sequencing; counter is zero unless counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (!sw_s.chase) begin
      state_d = (|sw_s.manual) ? S_MANUAL : S_OFF;
    end else begin
      unique case (state_q)
        S_OFF, S_MANUAL: state_d = S_CH1;
        S_CH1, S_CH2, S_CH3: begin
          if (cnt_q == DWELL_LAST_C) begin
            state_d = (GAP_CYCLES == 0) ? chase_next(state_q) : gap_of(state_q);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == GAP_LAST_C) begin
            state_d = chase_next(state_q);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Channel enables and chase index decoded from the current state.
  always_comb begin
    en_c   = '0;
    step_c = 2'd0;
    unique case (state_q)
      S_MANUAL: en_c = man_q;
      S_CH1: begin en_c = NUM_CH'(3'b001); step_c = 2'd1; end
      S_CH2: begin en_c = NUM_CH'(3'b010); step_c = 2'd2; end
      S_CH3: begin en_c = NUM_CH'(3'b100); step_c = 2'd3; end
      default: ;
    endcase
  end

  // Registered outputs: gated PWM, indicator LEDs and chase index.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      bus.pwm_out    <= '0;
      bus.led        <= '0;
      bus.chase_step <= '0;
    end else begin
      bus.pwm_out    <= bus.pwm_in & en_c;
      bus.led        <= (state_q == S_OFF && sw_s == '0) ? 2'b00 : sw_s.led;
      bus.chase_step <= step_c;
    end
  end

endmodule

// File: tb/tb_casca_sequencer.sv
// Scoreboard bench for casca_sequencer: one instance with a gap, one without.
module tb_casca_sequencer;
  import casca_pkg::*;

  localparam int unsigned DWELL = 8;
  localparam int unsigned GAP0  = 2;
  localparam int unsigned GAP1  = 0;

  typedef struct {
    int         edge_i;
    int         dut;
    logic [2:0] pwm;
    logic [1:0] led;
    logic [1:0] step;
  } exp_t;

  logic clk_50MHz = 1'b0;
  logic rst;
  int   edge_n = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  casca_sequencer_if bus0();
  casca_sequencer_if bus1();

  assign bus1.sw_manual = bus0.sw_manual;
  assign bus1.sw_chase  = bus0.sw_chase;
  assign bus1.sw_led    = bus0.sw_led;
  assign bus1.pwm_in    = bus0.pwm_in;

  casca_sequencer #(.DWELL_CYCLES(DWELL), .GAP_CYCLES(GAP0)) u_dut0 (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .bus       (bus0.slave)
  );

  casca_sequencer #(.DWELL_CYCLES(DWELL), .GAP_CYCLES(GAP1)) u_dut1 (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .bus       (bus1.slave)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz) edge_n++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50MHz);
      #1;
    end
  endtask

  task automatic push(input int e, input int dut, input logic [2:0] p,
                      input logic [1:0] l, input logic [1:0] s);
    exp_t x;
    x.edge_i = e; x.dut = dut; x.pwm = p; x.led = l; x.step = s;
    sb.push_back(x);
  endtask

  task automatic push_both(input int e, input logic [2:0] p,
                           input logic [1:0] l, input logic [1:0] s);
    push(e, 0, p, l, s);
    push(e, 1, p, l, s);
  endtask

  // Hand-derived chase pattern: dwell 8 lit, then gap cycles dark, channels 1,2,3.
  function automatic void chase_exp(input int gap, input int o,
                                    output logic [2:0] p, output logic [1:0] s);
    int per;
    int ph;
    int ch;
    per = DWELL + gap;
    ph  = o % per;
    ch  = (o / per) % 3;
    if (ph < DWELL) begin
      p = 3'(1 << ch);
      s = 2'(ch + 1);
    end else begin
      p = 3'b000;
      s = 2'd0;
    end
  endfunction

  task automatic push_chase(input int e, input int base, input logic [1:0] l);
    logic [2:0] p;
    logic [1:0] s;
    chase_exp(GAP0, e - base, p, s);
    push(e, 0, p, l, s);
    chase_exp(GAP1, e - base, p, s);
    push(e, 1, p, l, s);
  endtask

  // Monitor: every cycle, pop the entries due at this edge and compare.
  always @(negedge clk_50MHz) begin
    while (sb.size() > 0 && sb[0].edge_i <= edge_n) begin
      exp_t x;
      logic [2:0] ap;
      logic [1:0] al;
      logic [1:0] as_;
      x = sb.pop_front();
      ap  = (x.dut == 0) ? bus0.pwm_out    : bus1.pwm_out;
      al  = (x.dut == 0) ? bus0.led        : bus1.led;
      as_ = (x.dut == 0) ? bus0.chase_step : bus1.chase_step;
      checks++;
      if (x.edge_i < edge_n) begin
        errors++;
        $display("FAIL missed_check dut%0d edge %0d not compared (now %0d)",
                 x.dut, x.edge_i, edge_n);
      end else if (ap !== x.pwm || al !== x.led || as_ !== x.step) begin
        errors++;
        $display("FAIL outputs dut%0d edge %0d: pwm_out=%b led=%b chase_step=%0d, required pwm_out=%b led=%b chase_step=%0d",
                 x.dut, edge_n, ap, al, as_, x.pwm, x.led, x.step);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int k;
    int cb;
    rst = 1'b1;
    bus0.sw_manual = 3'b000;
    bus0.sw_chase  = 1'b0;
    bus0.sw_led    = 2'b00;
    bus0.pwm_in    = 3'b111;

    // Reset: all outputs held low.
    repeat (3) begin
      tick(1);
      push_both(edge_n, 3'b000, 2'b00, 2'd0);
    end
    rst = 1'b0;
    k = edge_n;
    push_both(k + 1, 3'b000, 2'b00, 2'd0);
    push_both(k + 2, 3'b000, 2'b00, 2'd0);
    tick(2);

    // Manual 101 with LED switch: pwm at E+3, led one edge earlier.
    k = edge_n;
    bus0.sw_manual = 3'b101;
    bus0.sw_led    = 2'b10;
    for (int e = 1; e <= 8; e++)
      push_both(k + e, (e >= 4) ? 3'b101 : 3'b000, (e >= 3) ? 2'b10 : 2'b00, 2'd0);
    tick(8);

    // pwm_in gating with one-cycle latency.
    k = edge_n;
    bus0.pwm_in = 3'b001;
    push_both(k + 1, 3'b001, 2'b10, 2'd0);
    push_both(k + 2, 3'b001, 2'b10, 2'd0);
    tick(2);
    k = edge_n;
    bus0.pwm_in = 3'b111;
    push_both(k + 1, 3'b101, 2'b10, 2'd0);
    push_both(k + 2, 3'b101, 2'b10, 2'd0);
    tick(2);

    // Chase with manual 010 held: full cycle plus wrap back to CH1.
    k = edge_n;
    bus0.sw_manual = 3'b010;
    bus0.sw_chase  = 1'b1;
    for (int e = 1; e <= 3; e++) push_both(k + e, 3'b101, 2'b10, 2'd0);
    cb = k + 4;
    for (int e = 4; e <= 56; e++) push_chase(k + e, cb, 2'b10);
    tick(56);

    // Drop chase while in CH3: manual 010 shows up three edges later.
    k = edge_n;
    bus0.sw_chase = 1'b0;
    for (int e = 1; e <= 3; e++) push_chase(k + e, cb, 2'b10);
    for (int e = 4; e <= 6; e++) push_both(k + e, 3'b010, 2'b10, 2'd0);
    tick(6);

    // Re-enter chase, reset during cycle 5 of CH2, restart at CH1.
    k = edge_n;
    bus0.sw_chase = 1'b1;
    for (int e = 1; e <= 3; e++) push_both(k + e, 3'b010, 2'b10, 2'd0);
    cb = k + 4;
    for (int e = 4; e <= 17; e++) push_chase(k + e, cb, 2'b10);
    tick(17);
    rst = 1'b1;
    push_both(edge_n + 1, 3'b000, 2'b00, 2'd0);
    tick(1);
    rst = 1'b0;
    k = edge_n;
    push_both(k + 1, 3'b000, 2'b00, 2'd0);
    push_both(k + 2, 3'b000, 2'b00, 2'd0);
    push_both(k + 3, 3'b000, 2'b10, 2'd0);
    cb = k + 4;
    for (int e = 4; e <= 45; e++) push_chase(k + e, cb, 2'b10);
    tick(45);

    // All switches off: everything, including the counter, back to zero.
    k = edge_n;
    bus0.sw_chase  = 1'b0;
    bus0.sw_manual = 3'b000;
    bus0.sw_led    = 2'b00;
    push_chase(k + 1, cb, 2'b10);
    push_chase(k + 2, cb, 2'b10);
    push_chase(k + 3, cb, 2'b00);
    for (int e = 4; e <= 8; e++) push_both(k + e, 3'b000, 2'b00, 2'd0);
    tick(3);
    checks++;
    if (u_dut0.cnt_q !== '0 || u_dut1.cnt_q !== '0) begin
      errors++;
      $display("FAIL counter_idle: cnt0=%0d cnt1=%0d, required 0 and 0",
               u_dut0.cnt_q, u_dut1.cnt_q);
    end
    tick(5);
    tick(2);

    if (sb.size() != 0) begin
      errors += sb.size();
      checks += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations never compared, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
